mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly downstream of the icache/dcache pair and arbitrates their miss traffic onto the single-port RAM.
- Registered grant FSM; dcache has priority, with a starvation guard for icache.
- Holds a dcache grant across a block burst, bounded by BURST_LEN.
- Flat ports; the parent wires these to the cache-control interface.

Parameters:
- ADDR_W, 32, word address width
- DATA_W, 32, data word width
- BURST_LEN, 2, max consecutive dcache accesses per grant (block size in words)
- STARVE_LIMIT, 8, icache wait cycles before it preempts dcache at the next arbitration point

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  icache read request
- iaddr  in  ADDR_W  icache address
- iwait  out  1  icache stall; 0 only in the cycle its access completes
- iload  out  DATA_W  icache read data
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache address
- dstore  in  DATA_W  dcache write data
- dwait  out  1  dcache stall; 0 only in the cycle its access completes
- dload  out  DATA_W  dcache read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- ram_err  out  1  one-cycle pulse when a granted access ends in ERROR

Behaviour:
- States: IDLE, IGRANT, DGRANT. The state register is reset asynchronously to IDLE.
- Reset values:
  - iwait=1, dwait=1, iload=0, dload=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, ram_err=0.
  - starve_cnt=0, burst_cnt=0.
- A mid-transfer reset abandons the access; no completion is signalled.
- IDLE:
  - No RAM enables are driven.
  - Next state is DGRANT if (dREN|dWEN) and not (iREN and starve_cnt>=STARVE_LIMIT).
  - Otherwise next state is IGRANT if iREN; otherwise stay in IDLE.
  - Arbitration latency is one cycle.
- IGRANT:
  - ramREN=iREN, ramaddr=iaddr, ramWEN=0.
  - iwait = ~(ramstate==ACCESS || ramstate==ERROR).
  - iload=ramload when ramstate==ACCESS, else 0.
- DGRANT:
  - ramWEN=dWEN; ramREN=dREN & ~dWEN (write wins if both are asserted).
  - ramaddr=daddr, ramstore=dstore.
  - dwait and dload follow the same rules as the icache side.
- The non-granted requester always sees wait=1 and load=0.
- Completion is ramstate==ACCESS or ERROR while granted.
  - ERROR additionally pulses ram_err for that cycle; the requester still sees wait=0 and load=0.
- IGRANT on completion → IDLE.
- DGRANT on completion:
  - burst_cnt increments.
  - If burst_cnt+1 < BURST_LEN and (dREN|dWEN) is still asserted next cycle, stay in DGRANT.
  - Otherwise → IDLE and clear burst_cnt.
- Request withdrawn while granted, before completion → IDLE next cycle and clear burst_cnt. RAM enables drop combinationally in the same cycle.
- starve_cnt:
  - Increments (saturating at 2^8-1) each cycle iREN=1 and state!=IGRANT.
  - Clears on entry to IGRANT, and whenever iREN=0.
  - Preemption is checked only in IDLE; an active dcache burst is never broken mid-block.
- All outputs are combinational from state plus inputs; there are no registered data paths. Zero extra latency beyond arbitration.
- Both requesters asserting in the same IDLE cycle: dcache wins unless the starvation guard is tripped.

Decomposition:
- Shared package (cpu_types or similar):
  - ramstate_t enum {FREE, BUSY, ACCESS, ERROR}.
  - arb_state_t enum {IDLE, IGRANT, DGRANT}.
  - word_t.
- One natural sub-module: arb_starve_ctr, a saturating counter with clear, enable and a >=LIMIT compare.
- The FSM and muxing stay in mem_arbiter.

Test Plan:
- iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0x1234 → IGRANT at cycle 1; iwait=0 only at cycle 3, iload=0x1234; back to IDLE at cycle 4.
- iREN and dREN asserted together from IDLE, starve_cnt=0 → DGRANT; ramaddr=daddr; iwait=1 throughout; icache is served after dcache completes.
- dWEN held for a 2-word block (daddr 0x100, then 0x104), BURST_LEN=2 → DGRANT held for both words; ramWEN=1 with matching ramstore; IDLE after the 2nd ACCESS.
- Continuous dcache traffic with iREN held for 8+ cycles → next IDLE arbitration grants IGRANT; starve_cnt clears; the dcache burst in progress was not interrupted.
- Granted dREN; ramstate=ERROR → dwait=0, dload=0, ram_err=1 for exactly one cycle; IDLE next cycle.
- nRST asserted mid-DGRANT with ramWEN=1 → ramWEN=0 and dwait=1 immediately (asynchronous); state is IDLE after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the icache/dcache-to-RAM arbiter.
package mem_arbiter_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned STARVE_W = 8;

    typedef logic [WORD_W-1:0] word_t;

    // RAM handshake status as seen on ramstate.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    // An access ends on either a good or a failed RAM cycle.
    function automatic logic ram_done(ramstate_t rs);
        return (rs == ACCESS) || (rs == ERROR);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating wait counter for the icache starvation guard.
module arb_starve_ctr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LIMIT = 8
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    input  logic en,
    output logic starved
);

    logic [WIDTH-1:0] cnt;

    // Clear has priority over counting; the count sticks at all-ones.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign starved = (32'(cnt) >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache miss traffic onto a single-port RAM.
// dcache has priority; a starved icache wins the next IDLE arbitration.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned BURST_LEN    = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ram_err
);

    localparam int unsigned BurstW = $clog2(BURST_LEN + 1);

    arb_state_t        state;
    logic [BurstW-1:0] burst_cnt;
    ramstate_t         rs;
    logic              dreq;
    logic              done;
    logic              starved;
    logic              pick_d;
    logic              pick_i;
    logic              burst_more;
    logic              starve_clr;
    logic              starve_en;

    assign rs         = ramstate_t'(ramstate);
    assign dreq       = dREN | dWEN;
    assign done       = ram_done(rs);
    assign pick_d     = (state == IDLE) && dreq && !(iREN && starved);
    assign pick_i     = (state == IDLE) && !pick_d && iREN;
    assign burst_more = (32'(burst_cnt) + 32'd1) < BURST_LEN;

    // Waiting counts only while icache is asking and not being served.
    assign starve_clr = ~iREN | pick_i;
    assign starve_en  = iREN & (state != IGRANT);

    arb_starve_ctr #(
        .WIDTH (STARVE_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .CLK     (CLK),
        .nRST    (nRST),
        .clr     (starve_clr),
        .en      (starve_en),
        .starved (starved)
    );

    // Grant FSM and dcache burst length tracking.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    if (pick_d) begin
                        state <= DGRANT;
                    end else if (pick_i) begin
                        state <= IGRANT;
                    end
                end
                IGRANT: begin
                    if (!iREN || done) begin
                        state <= IDLE;
                    end
                end
                DGRANT: begin
                    if (!dreq) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end else if (done) begin
                        // A failed word ends the block so the error is not compounded.
                        if ((rs == ERROR) || !burst_more) begin
                            state     <= IDLE;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    // RAM-side muxing and requester handshakes, purely from state plus inputs.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ram_err  = 1'b0;
        case (state)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = ~done;
                iload   = (rs == ACCESS) ? ramload : '0;
                ram_err = (rs == ERROR);
            end
            DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~done;
                dload    = (rs == ACCESS) ? ramload : '0;
                ram_err  = (rs == ERROR);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle-by-cycle vector table plus
// a hand-written asynchronous reset sequence, checked through a scoreboard.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, ram_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .BURST_LEN    (2),
        .STARVE_LIMIT (8)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .ram_err  (ram_err)
    );

    // {iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err}
    typedef logic [132:0] obs_t;

    typedef struct {
        string       nm;
        logic [2:0]  req;   // {iREN, dREN, dWEN}
        logic [1:0]  rs;
        logic [31:0] ia, da, ds, rl;
        obs_t        exp;
    } vec_t;

    typedef struct {
        string nm;
        obs_t  exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    obs_t idl;

    function automatic obs_t pk(input logic iw, input logic dw, input logic [31:0] il,
                                input logic [31:0] dl, input logic rr, input logic rw,
                                input logic [31:0] ra, input logic [31:0] rst,
                                input logic er);
        return {iw, dw, il, dl, rr, rw, ra, rst, er};
    endfunction

    function automatic void add(input string nm, input logic [2:0] req, input logic [1:0] rs,
                                input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] ds, input logic [31:0] rl, input obs_t exp);
        vec_t v;
        v.nm = nm; v.req = req; v.rs = rs;
        v.ia = ia; v.da = da; v.ds = ds; v.rl = rl; v.exp = exp;
        vecs.push_back(v);
    endfunction

    function automatic obs_t observed();
        return {iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err};
    endfunction

    task automatic expect_out(input string nm, input obs_t exp);
        sb_t e;
        e.nm = nm;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        sb_t  e;
        obs_t act;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: nothing expected, got %h", observed());
        end else begin
            e = sb.pop_front();
            act = observed();
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.nm, act, e.exp);
            end
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic [1:0] rs, input logic [31:0] ia,
                         input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rl);
        {iREN, dREN, dWEN} = req;
        ramstate = rs;
        iaddr = ia;
        daddr = da;
        dstore = ds;
        ramload = rl;
    endtask

    initial begin
        obs_t dg;
        idl = pk(1, 1, 0, 0, 0, 0, 0, 0, 0);

        // icache read with two BUSY cycles.
        add("i_arb",    3'b100, FREE,   32'h40, 0, 0, 0,          idl);
        add("i_busy1",  3'b100, BUSY,   32'h40, 0, 0, 0,          pk(1, 1, 0, 0, 1, 0, 32'h40, 0, 0));
        add("i_busy2",  3'b100, BUSY,   32'h40, 0, 0, 0,          pk(1, 1, 0, 0, 1, 0, 32'h40, 0, 0));
        add("i_access", 3'b100, ACCESS, 32'h40, 0, 0, 32'h1234,
            pk(0, 1, 32'h1234, 0, 1, 0, 32'h40, 0, 0));
        add("i_idle",   3'b000, FREE,   0, 0, 0, 0,               idl);

        // Simultaneous requests: dcache first, icache after.
        add("both_arb",   3'b110, FREE,   32'h80, 32'h200, 32'hdead, 0, idl);
        add("both_dbusy", 3'b110, BUSY,   32'h80, 32'h200, 32'hdead, 0,
            pk(1, 1, 0, 0, 1, 0, 32'h200, 32'hdead, 0));
        add("both_dacc",  3'b110, ACCESS, 32'h80, 32'h200, 32'hdead, 32'hbeef,
            pk(1, 0, 0, 32'hbeef, 1, 0, 32'h200, 32'hdead, 0));
        add("both_dwd",   3'b100, FREE,   32'h80, 32'h200, 32'hdead, 0,
            pk(1, 1, 0, 0, 0, 0, 32'h200, 32'hdead, 0));
        add("both_iarb",  3'b100, FREE,   32'h80, 32'h200, 32'hdead, 0, idl);
        add("both_iacc",  3'b100, ACCESS, 32'h80, 32'h200, 32'hdead, 32'h5555,
            pk(0, 1, 32'h5555, 0, 1, 0, 32'h80, 0, 0));
        add("both_idle",  3'b000, FREE,   0, 0, 0, 0, idl);

        // Two-word write block, then the burst bound forces IDLE.
        add("wr_arb",   3'b001, FREE,   0, 32'h100, 32'haaaa, 0, idl);
        add("wr0_busy", 3'b001, BUSY,   0, 32'h100, 32'haaaa, 0,
            pk(1, 1, 0, 0, 0, 1, 32'h100, 32'haaaa, 0));
        add("wr0_acc",  3'b001, ACCESS, 0, 32'h100, 32'haaaa, 32'h77,
            pk(1, 0, 0, 32'h77, 0, 1, 32'h100, 32'haaaa, 0));
        add("wr1_busy", 3'b001, BUSY,   0, 32'h104, 32'hbbbb, 0,
            pk(1, 1, 0, 0, 0, 1, 32'h104, 32'hbbbb, 0));
        add("wr1_acc",  3'b001, ACCESS, 0, 32'h104, 32'hbbbb, 0,
            pk(1, 0, 0, 0, 0, 1, 32'h104, 32'hbbbb, 0));
        add("wr_bound", 3'b001, FREE,   0, 32'h108, 32'hcccc, 0, idl);
        add("wr_wd",    3'b000, FREE,   0, 0, 0, 0, idl);

        // Continuous dcache traffic starves icache until cnt >= 8 at an IDLE point.
        dg = pk(1, 0, 0, 32'h11, 1, 0, 32'h400, 0, 0);
        for (int b = 0; b < 3; b++) begin
            add($sformatf("st_arb%0d", b), 3'b110, ACCESS, 32'h300, 32'h400, 0, 32'h11, idl);
            add($sformatf("st_d%0d_w0", b), 3'b110, ACCESS, 32'h300, 32'h400, 0, 32'h11, dg);
            add($sformatf("st_d%0d_w1", b), 3'b110, ACCESS, 32'h300, 32'h400, 0, 32'h11, dg);
        end
        add("st_preempt", 3'b110, ACCESS, 32'h300, 32'h400, 0, 32'h11, idl);
        add("st_iacc",    3'b110, ACCESS, 32'h300, 32'h400, 0, 32'h11,
            pk(0, 1, 32'h11, 0, 1, 0, 32'h300, 0, 0));
        add("st_cleared", 3'b110, ACCESS, 32'h300, 32'h400, 0, 32'h11, idl);

        // RAM errors: one-cycle ram_err, zero load, grant released.
        add("err_dacc",   3'b010, ACCESS, 0, 32'h400, 0, 32'h22,
            pk(1, 0, 0, 32'h22, 1, 0, 32'h400, 0, 0));
        add("err_derr",   3'b010, ERROR,  0, 32'h400, 0, 32'h33,
            pk(1, 0, 0, 0, 1, 0, 32'h400, 0, 1));
        add("err_after",  3'b010, ERROR,  0, 32'h400, 0, 32'h33, idl);
        add("err2_derr",  3'b010, ERROR,  0, 32'h400, 0, 32'h33,
            pk(1, 0, 0, 0, 1, 0, 32'h400, 0, 1));
        add("err2_after", 3'b000, FREE,   0, 0, 0, 0, idl);

        // Reset state, with requests and an ACCESS present.
        drive(3'b111, ACCESS, 32'h44, 32'h88, 32'hffff, 32'hffff);
        expect_out("reset", idl);
        @(negedge CLK);
        check_sb();
        drive(3'b000, FREE, 0, 0, 0, 0);
        #2 nRST = 1'b1;

        foreach (vecs[k]) begin
            @(posedge CLK);
            #1;
            drive(vecs[k].req, vecs[k].rs, vecs[k].ia, vecs[k].da, vecs[k].ds, vecs[k].rl);
            expect_out(vecs[k].nm, vecs[k].exp);
            @(negedge CLK);
            check_sb();
        end

        // Asynchronous reset in the middle of a granted write.
        @(posedge CLK);
        #1;
        drive(3'b001, BUSY, 0, 32'h500, 32'hcafe, 0);
        expect_out("rst_arb", idl);
        @(negedge CLK);
        check_sb();
        @(posedge CLK);
        #1;
        expect_out("rst_pre", pk(1, 1, 0, 0, 0, 1, 32'h500, 32'hcafe, 0));
        @(negedge CLK);
        check_sb();
        #1 nRST = 1'b0;
        #1;
        expect_out("rst_async", idl);
        check_sb();
        #1 nRST = 1'b1;
        #1;
        expect_out("rst_release", idl);
        check_sb();

        drive(3'b000, FREE, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
